// File: rtl/btn_deb_multi_ce.sv
// Multi-channel push-button conditioner: 2-FF synchronizer, tick-based debounce,
// and a per-channel IDLE/HELD/REPEAT machine producing press/release/long/repeat pulses.
module btn_deb_multi_ce #(
    parameter int N_CH      = 4,
    parameter int CE_HZ     = 1000,
    parameter int STABLE_MS = 5,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200,
    parameter int REPEAT_EN = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_ce,
    input  logic [N_CH-1:0] btn_n,
    output logic [N_CH-1:0] pressed,
    output logic [N_CH-1:0] press_pulse,
    output logic [N_CH-1:0] release_pulse,
    output logic [N_CH-1:0] long_pulse,
    output logic [N_CH-1:0] repeat_pulse,
    output logic            any_pressed
);

    localparam int STABLE_T = STABLE_MS * CE_HZ / 1000;
    localparam int LONG_T   = LONG_MS * CE_HZ / 1000;
    localparam int REPEAT_T = REPEAT_MS * CE_HZ / 1000;
    localparam int HOLD_MAX = (LONG_T > REPEAT_T) ? LONG_T : REPEAT_T;
    localparam int SW       = $clog2(STABLE_T) + 1;
    localparam int HW       = $clog2(HOLD_MAX) + 1;

    if (N_CH < 1 || N_CH > 32 || STABLE_T < 1 || LONG_T < 1 || REPEAT_T < 1
        || LONG_T <= STABLE_T) begin : g_param_check
        $error("btn_deb_multi_ce: illegal channel count or tick parameters");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } state_t;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic          sync1, sync2, lvl;
        logic          pressed_q, pressed_d;
        logic [SW-1:0] stab_q, stab_d;
        logic          rise, fall;
        state_t        state_q, state_d;
        logic [HW-1:0] hold_q, hold_d;
        logic          pp_q, pp_d, rp_q, rp_d, lp_q, lp_d, rpt_q, rpt_d;

        // Synchronizer runs every clk; resets to the released level.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1 <= 1'b1;
                sync2 <= 1'b1;
            end else begin
                sync1 <= btn_n[i];
                sync2 <= sync1;
            end
        end

        assign lvl = ~sync2;

        always_comb begin
            pressed_d = pressed_q;
            stab_d    = stab_q;
            rise      = 1'b0;
            fall      = 1'b0;
            if (sample_ce) begin
                if (lvl != pressed_q) begin
                    if (stab_q == SW'(STABLE_T - 1)) begin
                        pressed_d = lvl;
                        stab_d    = '0;
                        rise      = lvl;
                        fall      = ~lvl;
                    end else begin
                        stab_d = stab_q + SW'(1);
                    end
                end else begin
                    stab_d = '0;
                end
            end
        end

        // Release is checked first in HELD/REPEAT so it pre-empts a repeat due on the same tick.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            pp_d    = 1'b0;
            rp_d    = 1'b0;
            lp_d    = 1'b0;
            rpt_d   = 1'b0;
            if (sample_ce) begin
                pp_d = rise;
                rp_d = fall;
                case (state_q)
                    IDLE: begin
                        if (rise) begin
                            state_d = HELD;
                            hold_d  = '0;
                        end
                    end
                    HELD: begin
                        if (fall) begin
                            state_d = IDLE;
                            hold_d  = '0;
                        end else if (hold_q == HW'(LONG_T - 1)) begin
                            state_d = REPEAT;
                            hold_d  = '0;
                            lp_d    = 1'b1;
                        end else begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                    REPEAT: begin
                        if (fall) begin
                            state_d = IDLE;
                            hold_d  = '0;
                        end else if (REPEAT_EN != 0) begin
                            if (hold_q == HW'(REPEAT_T - 1)) begin
                                hold_d = '0;
                                rpt_d  = 1'b1;
                            end else begin
                                hold_d = hold_q + HW'(1);
                            end
                        end else if (hold_q < HW'(REPEAT_T)) begin
                            hold_d = hold_q + HW'(1);
                        end
                    end
                    default: begin
                        state_d = IDLE;
                        hold_d  = '0;
                    end
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                pressed_q <= 1'b0;
                stab_q    <= '0;
                state_q   <= IDLE;
                hold_q    <= '0;
                pp_q      <= 1'b0;
                rp_q      <= 1'b0;
                lp_q      <= 1'b0;
                rpt_q     <= 1'b0;
            end else begin
                pressed_q <= pressed_d;
                stab_q    <= stab_d;
                state_q   <= state_d;
                hold_q    <= hold_d;
                pp_q      <= pp_d;
                rp_q      <= rp_d;
                lp_q      <= lp_d;
                rpt_q     <= rpt_d;
            end
        end

        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = pp_q;
        assign release_pulse[i] = rp_q;
        assign long_pulse[i]    = lp_q;
        assign repeat_pulse[i]  = rpt_q;
    end

    assign any_pressed = |pressed;

endmodule

// File: tb/tb_btn_deb_multi_ce.sv
// Directed scenarios plus random button traffic against a window/arithmetic reference model,
// on two instances (auto-repeat enabled and disabled) driven by the same buttons.
module tb_btn_deb_multi_ce;
    localparam int N  = 4;
    localparam int ST = 5;
    localparam int LT = 20;
    localparam int RT = 10;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sample_ce = 1'b0;
    logic [N-1:0] btn_n = '1;

    logic [N-1:0] pressed_a, pp_a, rp_a, lp_a, rpt_a;
    logic [N-1:0] pressed_b, pp_b, rp_b, lp_b, rpt_b;
    logic         any_a, any_b;

    btn_deb_multi_ce #(.N_CH(N), .CE_HZ(1000), .STABLE_MS(5), .LONG_MS(20),
                       .REPEAT_MS(10), .REPEAT_EN(1)) dut_a (
        .clk(clk), .rst(rst), .sample_ce(sample_ce), .btn_n(btn_n),
        .pressed(pressed_a), .press_pulse(pp_a), .release_pulse(rp_a),
        .long_pulse(lp_a), .repeat_pulse(rpt_a), .any_pressed(any_a));

    btn_deb_multi_ce #(.N_CH(N), .CE_HZ(1000), .STABLE_MS(5), .LONG_MS(20),
                       .REPEAT_MS(10), .REPEAT_EN(0)) dut_b (
        .clk(clk), .rst(rst), .sample_ce(sample_ce), .btn_n(btn_n),
        .pressed(pressed_b), .press_pulse(pp_b), .release_pulse(rp_b),
        .long_pulse(lp_b), .repeat_pulse(rpt_b), .any_pressed(any_b));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: debounced level flips once the last ST samples all disagree with it;
    // long/repeat timing is plain arithmetic on ticks elapsed since the debounced press.
    bit [ST-1:0]  hist [N];
    bit [N-1:0]   deb;
    int           press_tick [N];
    int           tick_n = 0;
    logic [N-1:0] e_pp, e_rp, e_lp, e_rpt;

    int c_pp [N], c_rp [N], c_lp [N], c_rpt [N], c_lp_b [N], c_rpt_b [N], c_hi [N];
    int t_pp [N], t_lp [N], t_rpt_first [N], t_rpt_last [N];
    int pp_cycles;
    logic [N-1:0] first_pp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        deb = '0;
        for (int ch = 0; ch < N; ch++) hist[ch] = '0;
    endtask

    task automatic model_update();
        int held;
        tick_n++;
        for (int ch = 0; ch < N; ch++) begin
            hist[ch] = {hist[ch][ST-2:0], ~btn_n[ch]};
            if ((deb[ch] && hist[ch] == '0) || (!deb[ch] && hist[ch] == '1)) begin
                deb[ch] = ~deb[ch];
                if (deb[ch]) begin
                    e_pp[ch] = 1'b1;
                    press_tick[ch] = tick_n;
                end else begin
                    e_rp[ch] = 1'b1;
                end
            end else if (deb[ch]) begin
                held = tick_n - press_tick[ch];
                if (held == LT) e_lp[ch] = 1'b1;
                if (held > LT && (held - LT) % RT == 0) e_rpt[ch] = 1'b1;
            end
        end
    endtask

    task automatic clear_counts();
        pp_cycles = 0;
        first_pp  = '0;
        for (int ch = 0; ch < N; ch++) begin
            c_pp[ch] = 0; c_rp[ch] = 0; c_lp[ch] = 0; c_rpt[ch] = 0;
            c_lp_b[ch] = 0; c_rpt_b[ch] = 0; c_hi[ch] = 0;
            t_pp[ch] = -1; t_lp[ch] = -1; t_rpt_first[ch] = -1; t_rpt_last[ch] = -1;
        end
    endtask

    task automatic observe();
        chk("pressed_a", 32'(pressed_a), 32'(deb));
        chk("press_a", 32'(pp_a), 32'(e_pp));
        chk("release_a", 32'(rp_a), 32'(e_rp));
        chk("long_a", 32'(lp_a), 32'(e_lp));
        chk("repeat_a", 32'(rpt_a), 32'(e_rpt));
        chk("any_a", 32'(any_a), 32'(|deb));
        chk("pressed_b", 32'(pressed_b), 32'(deb));
        chk("press_b", 32'(pp_b), 32'(e_pp));
        chk("release_b", 32'(rp_b), 32'(e_rp));
        chk("long_b", 32'(lp_b), 32'(e_lp));
        chk("repeat_b", 32'(rpt_b), 32'h0);
        chk("any_b", 32'(any_b), 32'(|deb));
        if (pp_a != '0) begin
            if (pp_cycles == 0) first_pp = pp_a;
            pp_cycles++;
        end
        for (int ch = 0; ch < N; ch++) begin
            if (pp_a[ch]) begin c_pp[ch]++; t_pp[ch] = tick_n; end
            if (rp_a[ch]) c_rp[ch]++;
            if (lp_a[ch]) begin c_lp[ch]++; t_lp[ch] = tick_n; end
            if (rpt_a[ch]) begin
                if (c_rpt[ch] == 0) t_rpt_first[ch] = tick_n;
                t_rpt_last[ch] = tick_n;
                c_rpt[ch]++;
            end
            if (lp_b[ch]) c_lp_b[ch]++;
            if (rpt_b[ch]) c_rpt_b[ch]++;
            if (pressed_a[ch]) c_hi[ch]++;
        end
    endtask

    // One sample tick = 4 clks; buttons are applied before the call so both sync stages settle.
    task automatic tick();
        for (int c = 0; c < 4; c++) begin
            sample_ce = (c == 3);
            @(posedge clk);
            e_pp = '0; e_rp = '0; e_lp = '0; e_rpt = '0;
            if (rst) model_reset();
            else if (c == 3) model_update();
            #1;
            observe();
            @(negedge clk);
        end
        sample_ce = 1'b0;
    endtask

    task automatic hold(input logic [N-1:0] b, input int n);
        btn_n = b;
        for (int k = 0; k < n; k++) tick();
    endtask

    int b_tick, d_tick, sum;
    logic [N-1:0] rb;

    initial begin
        model_reset();
        clear_counts();
        @(negedge clk);
        rst = 1'b1;
        hold('1, 2);
        rst = 1'b0;
        hold('1, 3);

        // ch0 bounce then steady low
        clear_counts();
        hold(4'b1110, 3);
        hold(4'b1111, 1);
        b_tick = tick_n;
        hold(4'b1110, 30);
        chk("s1_rise_delay", 32'(t_pp[0] - b_tick), 32'd5);
        hold('1, 10);
        chk("s1_press_cnt", 32'(c_pp[0]), 32'd1);
        sum = 0;
        for (int ch = 1; ch < N; ch++) sum += c_pp[ch] + c_rp[ch] + c_lp[ch] + c_rpt[ch];
        chk("s1_other_ch", 32'(sum), 32'd0);

        // ch1 long hold; release coincides with a due repeat
        clear_counts();
        hold(4'b1101, 50);
        hold('1, 10);
        chk("s2_press_cnt", 32'(c_pp[1]), 32'd1);
        chk("s2_long_cnt", 32'(c_lp[1]), 32'd1);
        chk("s2_long_delay", 32'(t_lp[1] - t_pp[1]), 32'd20);
        chk("s2_repeat_cnt", 32'(c_rpt[1]), 32'd2);
        chk("s2_repeat_first", 32'(t_rpt_first[1] - t_lp[1]), 32'd10);
        chk("s2_repeat_last", 32'(t_rpt_last[1] - t_lp[1]), 32'd20);
        chk("s2_release_cnt", 32'(c_rp[1]), 32'd1);

        // ch2 glitch shorter than the window
        clear_counts();
        hold(4'b1011, 4);
        hold('1, 10);
        sum = 0;
        for (int ch = 0; ch < N; ch++) sum += c_pp[ch] + c_rp[ch] + c_lp[ch] + c_rpt[ch];
        chk("s3_pulses", 32'(sum), 32'd0);
        chk("s3_pressed_hi", 32'(c_hi[2]), 32'd0);

        // ch0 and ch3 together
        clear_counts();
        hold(4'b0110, 8);
        chk("s4_press_vec", 32'(first_pp), 32'h9);
        chk("s4_press_cycles", 32'(pp_cycles), 32'd1);
        chk("s4_any", 32'(any_a), 32'd1);
        hold('1, 8);

        // reset while ch1 is repeating, button kept held
        clear_counts();
        hold(4'b1101, 35);
        chk("s5_in_repeat", 32'(c_rpt[1]), 32'd1);
        rst = 1'b1;
        hold(4'b1101, 2);
        rst = 1'b0;
        d_tick = tick_n;
        hold(4'b1101, 10);
        chk("s5_repress_delay", 32'(t_pp[1] - d_tick), 32'd5);
        chk("s5_no_release", 32'(c_rp[1]), 32'd0);
        hold('1, 10);

        // 60-tick hold: repeat on vs off
        clear_counts();
        hold(4'b1011, 60);
        hold('1, 10);
        chk("s6_long_b", 32'(c_lp_b[2]), 32'd1);
        chk("s6_repeat_b", 32'(c_rpt_b[2]), 32'd0);
        chk("s6_repeat_a", 32'(c_rpt[2]), 32'd3);

        // random traffic, compared cycle by cycle against the model
        rb = '1;
        for (int k = 0; k < 400; k++) begin
            for (int ch = 0; ch < N; ch++)
                if ($urandom_range(0, 9) == 0) rb[ch] = ~rb[ch];
            hold(rb, 1);
        end
        hold('1, 10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/btn_deb_multi_ce.md
BTN_DEB_MULTI_CE -- requirements
Module: btn_deb_multi_ce

Interface
REQ-001 SHALL have parameter N_CH, default 4: number of independent button channels, 1..32.
REQ-002 SHALL have parameter CE_HZ, default 1000: sample_ce rate in Hz.
REQ-003 SHALL have parameter STABLE_MS, default 5: debounce stability window in ms.
REQ-004 SHALL have parameter LONG_MS, default 1000: hold time before long_pulse, in ms.
REQ-005 SHALL have parameter REPEAT_MS, default 200: auto-repeat period after long press, in ms.
REQ-006 SHALL have parameter REPEAT_EN, default 1: 1 enables auto-repeat, 0 disables it.
REQ-007 SHALL have port clk, input, 1: the single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port sample_ce, input, 1: one-clk-wide sample strobe at CE_HZ.
REQ-010 SHALL have port btn_n, input, N_CH: raw asynchronous buttons, active-low.
REQ-011 SHALL have port pressed, output, N_CH: debounced level, 1 = held.
REQ-012 SHALL have port press_pulse, output, N_CH: one-clk pulse on debounced press.
REQ-013 SHALL have port release_pulse, output, N_CH: one-clk pulse on debounced release.
REQ-014 SHALL have port long_pulse, output, N_CH: one-clk pulse when hold reaches LONG_MS.
REQ-015 SHALL have port repeat_pulse, output, N_CH: one-clk pulse every REPEAT_MS after long_pulse.
REQ-016 SHALL have port any_pressed, output, 1: OR-reduction of pressed.

Function
REQ-017 SHALL derive ticks as STABLE_T = STABLE_MS*CE_HZ/1000, LONG_T = LONG_MS*CE_HZ/1000 and REPEAT_T = REPEAT_MS*CE_HZ/1000, and stop elaboration if any tick count is < 1 or if LONG_T <= STABLE_T.
REQ-018 SHALL size each counter as clog2 of its largest terminal count plus 1, with no wrap-around.
REQ-019 SHALL pass each btn_n bit through a 2-FF synchronizer clocked every clk, with reset value 1 (released).
REQ-020 SHALL change debounce, hold and state registers only in cycles where sample_ce = 1; synchronizers are the only exception.
REQ-021 SHALL, per channel on each sample_ce: if the synchronized level differs from pressed, increment the stable count; otherwise clear it.
REQ-022 SHALL toggle pressed and clear the count when the stable count reaches STABLE_T, so any glitch shorter than STABLE_T ticks is rejected.
REQ-023 SHALL run a per-channel FSM with states IDLE, HELD and REPEAT: IDLE->HELD on debounced press; HELD->REPEAT when the hold count reaches LONG_T; HELD or REPEAT->IDLE on debounced release.
REQ-024 SHALL clear the hold count on entry to HELD and increment it on each sample_ce while in HELD or REPEAT.
REQ-025 SHALL assert press_pulse and release_pulse in the same clk cycle that pressed changes, for exactly one clk.
REQ-026 SHALL assert long_pulse for one clk on the HELD->REPEAT transition.
REQ-027 SHALL, in REPEAT with REPEAT_EN = 1, assert repeat_pulse for one clk every REPEAT_T ticks, the first being REPEAT_T ticks after long_pulse, and restart its counter on each pulse.
REQ-028 SHALL, with REPEAT_EN = 0, keep repeat_pulse at 0 and hold the REPEAT-state counter saturated.
REQ-029 SHALL emit no repeat_pulse when release occurs on the same tick a repeat is due; release_pulse wins.
REQ-030 SHALL keep channels fully independent, so simultaneous events on several channels assert their own bits in the same cycle.
REQ-031 SHALL keep every pulse output exactly one clk wide, regardless of sample_ce spacing.

Reset
REQ-032 SHALL, while rst = 1, drive all outputs to 0, set synchronizers to 1, clear all counters and put every FSM in IDLE.
REQ-033 SHALL, when rst is asserted mid-press, drive pressed to 0 in the next cycle, generate no release_pulse, and require a fresh STABLE_T window after rst deasserts.

Verification
Bench settings: N_CH=4, CE_HZ=1000, STABLE_MS=5, LONG_MS=20, REPEAT_MS=10; sample_ce every 4 clk.
REQ-034 SHALL verify: ch0 bounce of 3 tick low / 1 tick high / steady low for 30 ticks -> exactly 1 press_pulse, pressed=1 no earlier than 5 ticks after the last bounce, and 0 pulses on ch1-3.
REQ-035 SHALL verify: ch1 held low for 50 ticks -> 1 press_pulse, 1 long_pulse 20 ticks after pressed rises, repeat_pulse at +10 and +20 ticks after it, then 1 release_pulse after release.
REQ-036 SHALL verify: ch2 low for 4 ticks then high -> pressed stays 0 with no pulses on any output.
REQ-037 SHALL verify: ch0 and ch3 pressed on the same clk -> press_pulse = 4'b1001 in a single cycle and any_pressed = 1.
REQ-038 SHALL verify: rst asserted while ch1 is in REPEAT -> all outputs 0 the next cycle, no release_pulse, and with the button still held a new press_pulse 5 ticks after rst drops.
REQ-039 SHALL verify: with REPEAT_EN=0 and a 60-tick hold -> exactly 1 long_pulse and 0 repeat_pulse.
